// File: rtl/des_pkg.sv
// des_pkg: FSM state encoding, block geometry and status bit positions shared by
// the DES block sequencer and its bench.
package des_pkg;

  localparam int BLK_WORDS = 4;

  localparam int ST_DROPPED_BUSY = 0;
  localparam int ST_OVERFLOW     = 1;
  localparam int ST_RD_UNDERRUN  = 2;
  localparam int ST_TIMEOUT      = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_FIN   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/des_seq_ram.sv
// des_seq_ram: single-port word buffer with registered read (1-cycle latency).
// The read register only updates on read cycles, so it holds the last word read.
module des_seq_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH_WORDS];
  logic [15:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (en && !we) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/des_block_sequencer.sv
// des_block_sequencer: buffers host pipe words in a local RAM, runs each 64-bit block
// through des_core and writes results back in place. Core watchdog: `DES_SEQ_TIMEOUT_EN.
module des_block_sequencer
  import des_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ptr_reset,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic        pi_write,
  input  logic [15:0] pi_data,
  input  logic        po_read,
  output logic [15:0] po_data,
  output logic        core_start,
  output logic        core_decrypt,
  output logic [63:0] core_key,
  output logic [63:0] core_din,
  input  logic        core_done,
  input  logic [63:0] core_dout,
  output logic        done,
  output logic        busy,
  output logic [3:0]  status
);

  localparam int BW  = $clog2(BLK_WORDS);
  localparam int NBW = AW - BW;
  localparam logic [AW:0] DEPTH_PTR = (AW+1)'(DEPTH_WORDS);

  seq_state_t     state_reg, state_next;
  logic [NBW-1:0] blk_reg, blk_next;
  logic [BW:0]    sub_reg, sub_next;
  logic [63:0]    data_reg, data_next;
  logic [63:0]    key_reg, key_next;
  logic           dec_reg, dec_next;
  logic [AW:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW:0]    rd_ptr_reg, rd_ptr_next;
  logic [3:0]     status_reg, status_next;
  logic           po_sel_reg, po_sel_next;

  logic           ram_en, ram_we;
  logic [AW-1:0]  ram_addr;
  logic [15:0]    ram_wdata, ram_rdata;

  logic [BLK_WORDS-1:0] word_valid;
  logic [AW:0]          next_blk_base;
  logic                 last_blk;
  logic [BW-1:0]        sub_idx, cap_idx;

`ifdef DES_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt_reg, wait_cnt_next;
`endif

  // A word slot of the current block is real data only if it lies below wr_ptr.
  for (genvar gi = 0; gi < BLK_WORDS; gi++) begin : g_valid
    assign word_valid[gi] = ({1'b0, blk_reg, BW'(gi)} < wr_ptr_reg);
  end

  assign next_blk_base = {1'b0, blk_reg, BW'(0)} + (AW+1)'(BLK_WORDS);
  assign last_blk      = (next_blk_base >= wr_ptr_reg);
  assign sub_idx       = sub_reg[BW-1:0];
  assign cap_idx       = sub_idx - BW'(1);

  des_seq_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      blk_reg    <= '0;
      sub_reg    <= '0;
      data_reg   <= '0;
      key_reg    <= '0;
      dec_reg    <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      status_reg <= '0;
      po_sel_reg <= 1'b0;
`ifdef DES_SEQ_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      blk_reg    <= blk_next;
      sub_reg    <= sub_next;
      data_reg   <= data_next;
      key_reg    <= key_next;
      dec_reg    <= dec_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      status_reg <= status_next;
      po_sel_reg <= po_sel_next;
`ifdef DES_SEQ_TIMEOUT_EN
      wait_cnt_reg <= wait_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    blk_next    = blk_reg;
    sub_next    = sub_reg;
    data_next   = data_reg;
    key_next    = key_reg;
    dec_next    = dec_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    status_next = status_reg;
    po_sel_next = po_sel_reg;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    core_start  = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
`ifdef DES_SEQ_TIMEOUT_EN
    wait_cnt_next = wait_cnt_reg;
`endif

    // FIN still owns the RAM, so a write there is dropped like any busy write.
    if (state_reg != S_IDLE && pi_write) begin
      status_next[ST_DROPPED_BUSY] = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        // One RAM port: ptr_reset beats a write, a write beats a read.
        if (ptr_reset) begin
          wr_ptr_next = '0;
          rd_ptr_next = '0;
          status_next = '0;
        end else if (pi_write) begin
          if (wr_ptr_reg == DEPTH_PTR) begin
            status_next[ST_OVERFLOW] = 1'b1;
          end else begin
            ram_en      = 1'b1;
            ram_we      = 1'b1;
            ram_addr    = wr_ptr_reg[AW-1:0];
            ram_wdata   = pi_data;
            wr_ptr_next = wr_ptr_reg + (AW+1)'(1);
          end
        end else if (po_read) begin
          if (rd_ptr_reg >= wr_ptr_reg) begin
            status_next[ST_RD_UNDERRUN] = 1'b1;
            po_sel_next                 = 1'b0;
          end else begin
            ram_en      = 1'b1;
            ram_addr    = rd_ptr_reg[AW-1:0];
            rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
            po_sel_next = 1'b1;
          end
        end
        if (start) begin
          key_next    = key;
          dec_next    = decrypt;
          blk_next    = '0;
          sub_next    = '0;
          po_sel_next = 1'b0;
          state_next  = (wr_ptr_reg == '0) ? S_FIN : S_LOAD;
        end
      end

      S_LOAD: begin
        busy = 1'b1;
        if (!sub_reg[BW]) begin
          ram_en   = word_valid[sub_idx];
          ram_addr = {blk_reg, sub_idx};
        end
        // Each captured word shifts in from the bottom, so word 0 ends in [63:48].
        if (sub_reg != '0) begin
          data_next = {data_reg[47:0], word_valid[cap_idx] ? ram_rdata : 16'h0000};
        end
        if (sub_reg[BW]) begin
          sub_next   = '0;
          state_next = S_KICK;
        end else begin
          sub_next = sub_reg + (BW+1)'(1);
        end
      end

      S_KICK: begin
        busy       = 1'b1;
        core_start = 1'b1;
        state_next = S_WAIT;
`ifdef DES_SEQ_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
      end

      S_WAIT: begin
        busy = 1'b1;
        if (core_done) begin
          data_next  = core_dout;
          state_next = S_STORE;
        end
`ifdef DES_SEQ_TIMEOUT_EN
        else if (wait_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
          status_next[ST_TIMEOUT] = 1'b1;
          state_next              = S_FIN;
        end else begin
          wait_cnt_next = wait_cnt_reg + TW'(1);
        end
`endif
      end

      S_STORE: begin
        busy      = 1'b1;
        ram_en    = word_valid[sub_idx];
        ram_we    = 1'b1;
        ram_addr  = {blk_reg, sub_idx};
        ram_wdata = data_reg[63:48];
        data_next = {data_reg[47:0], 16'h0000};
        if (sub_idx == BW'(BLK_WORDS - 1)) begin
          sub_next = '0;
          if (last_blk) begin
            state_next = S_FIN;
          end else begin
            blk_next   = blk_reg + NBW'(1);
            state_next = S_LOAD;
          end
        end else begin
          sub_next = sub_reg + (BW+1)'(1);
        end
      end

      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign po_data      = po_sel_reg ? ram_rdata : 16'h0000;
  assign core_decrypt = dec_reg;
  assign core_key     = key_reg;
  assign core_din     = data_reg;
  assign status       = status_reg;

endmodule
